// File: rtl/irq_timer_if.sv
// Device-bridge port bundle for irq_timer: register bus plus the interrupt line.
interface irq_timer_if;
  // No valid/ready pair: we is a one-cycle write strobe taken at posedge clk,
  // rdata always reflects the register selected by addr, irq is level output.
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output addr,
    output we,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  wdata,
    output rdata,
    output irq
  );
endinterface

// File: rtl/irq_timer.sv
// Memory-mapped countdown timer driving one CP0 hardware-interrupt bit.
// Build option IRQ_TIMER_STATUS_EN adds a STATUS register at addr 3 with write-1-to-clear.
module irq_timer #(
  parameter logic [31:0] RESET_PRESET = 32'd0,
  parameter int          CNT_W        = 32
) (
  input  logic       clk,
  input  logic       reset,
  irq_timer_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               en_q, en_d;
  logic [1:0]         mode_q, mode_d;
  logic               im_q, im_d;
  logic [CNT_W-1:0]   preset_q, preset_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               flag_q, flag_d;

  logic               wr_ctrl;
  logic               wr_preset;
  logic               flag_set;
  logic               flag_auto_clr;
  logic               flag_bus_clr;

  assign wr_ctrl   = bus.we && (bus.addr == 2'd0);
  assign wr_preset = bus.we && (bus.addr == 2'd1);

`ifdef IRQ_TIMER_STATUS_EN
  assign flag_bus_clr = bus.we && (bus.addr == 2'd3) && bus.wdata[0];
`else
  assign flag_bus_clr = wr_ctrl || wr_preset;
`endif

  always_comb begin
    state_d       = state_q;
    en_d          = en_q;
    mode_d        = mode_q;
    im_d          = im_q;
    preset_d      = preset_q;
    count_d       = count_q;
    flag_set      = 1'b0;
    flag_auto_clr = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_q) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          // A preset of 0 lands here too, so it fires like a preset of 1.
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (mode_q == 2'd1) begin
          flag_auto_clr = 1'b1;
          state_d       = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus writes come after the FSM so a CTRL write overrides the one-shot EN clear.
    if (wr_ctrl) begin
      en_d   = bus.wdata[0];
      mode_d = bus.wdata[2:1];
      im_d   = bus.wdata[3];
    end
    if (wr_preset) preset_d = bus.wdata[CNT_W-1:0];

    // Set has priority over every clear so an interrupt is never dropped.
    if (flag_set) begin
      flag_d = 1'b1;
    end else if (flag_auto_clr || flag_bus_clr) begin
      flag_d = 1'b0;
    end else begin
      flag_d = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'd0;
      im_q     <= 1'b0;
      preset_q <= RESET_PRESET[CNT_W-1:0];
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      2'd0: bus.rdata = {28'd0, im_q, mode_q, en_q};
      2'd1: bus.rdata = 32'(preset_q);
      2'd2: bus.rdata = 32'(count_q);
`ifdef IRQ_TIMER_STATUS_EN
      2'd3: bus.rdata = {31'd0, flag_q};
`else
      2'd3: bus.rdata = 32'd0;
`endif
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq   = flag_q & im_q;
  assign dbg_state = state_q;

endmodule
